// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: takes one A/B/op command from the host and loads it into a
// strobe-loaded ALU top over a shared data bus (A, then B, then op). It waits
// one settle cycle, captures the ALU response and holds it until the host
// takes it. A saturating counter tracks how many transactions have completed.
module alu_op_sequencer #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [NB_OP-1:0]   i_op,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_en_A,
    output logic               o_en_B,
    output logic               o_en_OP,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_zero,
    input  logic               i_overflow,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_overflow,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic [15:0]        o_txn_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, LOAD_OP, SETTLE, RESP
    } state_t;

    state_t             state, state_nxt;
    logic [NB_DATA-1:0] a_q, b_q;
    logic [NB_OP-1:0]   op_q;
    logic [15:0]        txn_cnt;

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: one cycle per load/settle step, IDLE and RESP wait on handshakes
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_valid) state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = LOAD_OP;
            LOAD_OP: state_nxt = SETTLE;
            SETTLE:  state_nxt = RESP;
            RESP:    if (i_res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs decoded from state: bus and strobes are zero outside the load steps
    always_comb begin
        o_ready     = 1'b0;
        o_data      = '0;
        o_en_A      = 1'b0;
        o_en_B      = 1'b0;
        o_en_OP     = 1'b0;
        o_res_valid = 1'b0;
        case (state)
            IDLE:    o_ready = 1'b1;
            LOAD_A:  begin o_data = a_q; o_en_A = 1'b1; end
            LOAD_B:  begin o_data = b_q; o_en_B = 1'b1; end
            LOAD_OP: begin o_data = {{(NB_DATA-NB_OP){1'b0}}, op_q}; o_en_OP = 1'b1; end
            RESP:    o_res_valid = 1'b1;
            default: ;
        endcase
    end

    // latch the command only on acceptance, so later input changes are ignored
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (state == IDLE && i_valid) begin
            a_q  <= i_a;
            b_q  <= i_b;
            op_q <= i_op;
        end
    end

    // capture the ALU response on the edge that leaves SETTLE, then hold it
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_result   <= '0;
            o_zero     <= 1'b0;
            o_overflow <= 1'b0;
        end else if (state == SETTLE) begin
            o_result   <= i_result;
            o_zero     <= i_zero;
            o_overflow <= i_overflow;
        end
    end

    // count consumed responses, sticking at all-ones
    always_ff @(posedge i_clk) begin
        if (!i_rst)
            txn_cnt <= '0;
        else if (state == RESP && i_res_ready && txn_cnt != 16'hFFFF)
            txn_cnt <= txn_cnt + 16'd1;
    end

    assign o_txn_count = txn_cnt;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small strobe-loaded ALU model
// (add 0x20, sub 0x22, and 0x24) hanging off the shared data bus.
module tb_alu_op_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst, i_valid, i_res_ready;
    logic [7:0] i_a, i_b;
    logic [5:0] i_op;
    logic [7:0] o_data, i_result, o_result;
    logic       o_ready, o_en_A, o_en_B, o_en_OP;
    logic       i_zero, i_overflow, o_zero, o_overflow, o_res_valid;
    logic [15:0] o_txn_count;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    alu_op_sequencer #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_op(i_op), .o_data(o_data),
        .o_en_A(o_en_A), .o_en_B(o_en_B), .o_en_OP(o_en_OP),
        .i_result(i_result), .i_zero(i_zero), .i_overflow(i_overflow),
        .o_result(o_result), .o_zero(o_zero), .o_overflow(o_overflow),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_txn_count(o_txn_count)
    );

    // ALU top model: registers loaded by the strobes, combinational result
    logic [7:0] ra = 8'd0, rb = 8'd0;
    logic [5:0] rop = 6'd0;
    always @(posedge i_clk) begin
        if (o_en_A)  ra  <= o_data;
        if (o_en_B)  rb  <= o_data;
        if (o_en_OP) rop <= o_data[5:0];
    end
    always_comb begin
        i_result   = 8'd0;
        i_overflow = 1'b0;
        case (rop)
            6'h20: begin i_result = ra + rb; i_overflow = (ra[7] == rb[7]) && (i_result[7] != ra[7]); end
            6'h22: begin i_result = ra - rb; i_overflow = (ra[7] != rb[7]) && (i_result[7] != ra[7]); end
            6'h24: i_result = ra & rb;
            default: i_result = 8'd0;
        endcase
        i_zero = (i_result == 8'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobes(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, o_en_A, o_en_B, o_en_OP}, {29'd0, exp});
    endtask

    // one full command; hold = cycles the host stalls the response
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                           input logic [7:0] exp_r, input logic exp_z, input logic exp_o,
                           input int hold, input logic [15:0] exp_cnt);
        logic [7:0] op_bus;
        op_bus = {2'b00, op};
        @(negedge i_clk);
        i_valid = 1'b1; i_a = a; i_b = b; i_op = op;
        i_res_ready = (hold == 0);
        chk("idle_ready", o_ready, 1);
        @(negedge i_clk);                         // cycle N+1: LOAD_A
        i_valid = 1'b0; i_a = 8'hA5; i_b = 8'h5A; i_op = 6'h3F;
        strobes("ldA_strobe", 3'b100);
        chk("ldA_data", o_data, a);
        chk("ldA_ready", o_ready, 0);
        @(negedge i_clk);                         // N+2: LOAD_B
        strobes("ldB_strobe", 3'b010);
        chk("ldB_data", o_data, b);
        @(negedge i_clk);                         // N+3: LOAD_OP
        strobes("ldOP_strobe", 3'b001);
        chk("ldOP_data", o_data, op_bus);
        @(negedge i_clk);                         // N+4: SETTLE
        strobes("settle_strobe", 3'b000);
        chk("settle_data", o_data, 0);
        chk("settle_rv", o_res_valid, 0);
        @(negedge i_clk);                         // N+5: RESP
        chk("resp_rv", o_res_valid, 1);
        chk("resp_result", o_result, exp_r);
        chk("resp_zero", o_zero, exp_z);
        chk("resp_ovf", o_overflow, exp_o);
        chk("resp_ready", o_ready, 0);
        chk("resp_data", o_data, 0);
        for (int i = 0; i < hold; i++) begin
            i_valid = i[0];
            i_a = 8'(i);
            @(negedge i_clk);
            chk("bp_rv", o_res_valid, 1);
            chk("bp_result", o_result, exp_r);
            chk("bp_ready", o_ready, 0);
            strobes("bp_strobe", 3'b000);
        end
        i_valid = 1'b0;
        i_res_ready = 1'b1;
        @(negedge i_clk);                         // back in IDLE
        chk("done_ready", o_ready, 1);
        chk("done_rv", o_res_valid, 0);
        chk("done_count", o_txn_count, exp_cnt);
        chk("done_keep", o_result, exp_r);
    endtask

    initial begin
        i_rst = 1'b0; i_valid = 1'b1; i_res_ready = 1'b1;
        i_a = 8'hFF; i_b = 8'hFF; i_op = 6'h20;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1; i_valid = 1'b0;
        chk("rst_ready", o_ready, 1);
        chk("rst_data", o_data, 0);
        strobes("rst_strobe", 3'b000);
        chk("rst_rv", o_res_valid, 0);
        chk("rst_result", o_result, 0);
        chk("rst_flags", {o_zero, o_overflow}, 0);
        chk("rst_count", o_txn_count, 0);

        run_cmd(8'd123, 8'd45,  6'b100000, 8'd168, 1'b0, 1'b1, 0, 16'd1);
        run_cmd(8'd50,  8'd100, 6'b100010, 8'hCE,  1'b0, 1'b0, 0, 16'd2);
        run_cmd(8'd0,   8'd0,   6'b100000, 8'd0,   1'b1, 1'b0, 0, 16'd3);
        run_cmd(8'd255, 8'd15,  6'b100100, 8'd15,  1'b0, 1'b0, 0, 16'd4);
        run_cmd(8'd10,  8'd20,  6'b100000, 8'd30,  1'b0, 1'b0, 20, 16'd5);

        // idle with no command: captured response stays put
        repeat (3) @(negedge i_clk);
        chk("idle_keep", o_result, 8'd30);
        chk("idle_count", o_txn_count, 16'd5);

        // reset in the middle of LOAD_B, with i_valid asserted alongside it
        @(negedge i_clk);
        i_valid = 1'b1; i_a = 8'd7; i_b = 8'd9; i_op = 6'h20;
        @(negedge i_clk);
        i_valid = 1'b0;
        strobes("mid_ldA", 3'b100);
        @(negedge i_clk);
        strobes("mid_ldB", 3'b010);
        i_rst = 1'b0; i_valid = 1'b1; i_res_ready = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b1; i_valid = 1'b0;
        strobes("mrst_strobe", 3'b000);
        chk("mrst_rv", o_res_valid, 0);
        chk("mrst_ready", o_ready, 1);
        chk("mrst_count", o_txn_count, 0);
        chk("mrst_result", o_result, 0);
        run_cmd(8'd1, 8'd2, 6'b100000, 8'd3, 1'b0, 1'b0, 0, 16'd1);

        // jump the counter to one below saturation, then finish two more
        @(negedge i_clk);
        force dut.txn_cnt = 16'hFFFE;
        @(negedge i_clk);
        release dut.txn_cnt;
        chk("pre_sat", o_txn_count, 16'hFFFE);
        run_cmd(8'd4, 8'd4, 6'b100100, 8'd4, 1'b0, 1'b0, 0, 16'hFFFF);
        run_cmd(8'd200, 8'd100, 6'b100000, 8'd44, 1'b0, 1'b0, 0, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter NB_DATA, default 8, ALU operand/result width.
REQ-002 Parameter NB_OP, default 6, opcode width (NB_OP < NB_DATA).
REQ-003 i_clk  in  1  clock; all state changes on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-low.
REQ-005 i_valid  in  1  command request from host.
REQ-006 o_ready  out  1  sequencer idle, command accepted when i_valid&o_ready.
REQ-007 i_a, i_b  in  NB_DATA  operands A and B.
REQ-008 i_op  in  NB_OP  ALU opcode.
REQ-009 o_data  out  NB_DATA  shared data bus to ALU top.
REQ-010 o_en_A, o_en_B, o_en_OP  out  1 each  one-cycle load strobes to ALU top.
REQ-011 i_result  in  NB_DATA; i_zero, i_overflow  in  1  ALU outputs.
REQ-012 o_result  out  NB_DATA; o_zero, o_overflow  out  1  captured response.
REQ-013 o_res_valid  out  1  response valid; i_res_ready  in  1  host accepts response.
REQ-014 o_txn_count  out  16  completed-transaction count.

Function
REQ-015 FSM states IDLE, LOAD_A, LOAD_B, LOAD_OP, SETTLE, RESP; one state per cycle except IDLE/RESP.
REQ-016 IDLE: o_ready=1; on i_valid=1, latch i_a/i_b/i_op into internal registers, go LOAD_A.
REQ-017 LOAD_A: o_data=latched A, o_en_A=1, others 0; go LOAD_B.
REQ-018 LOAD_B: o_data=latched B, o_en_B=1; go LOAD_OP.
REQ-019 LOAD_OP: o_data={zero-pad, latched op} (upper NB_DATA-NB_OP bits 0), o_en_OP=1; go SETTLE.
REQ-020 SETTLE: no strobes; at edge leaving SETTLE capture i_result/i_zero/i_overflow into o_result/o_zero/o_overflow; go RESP.
REQ-021 RESP: o_res_valid=1, captured outputs held stable; on i_res_ready=1 go IDLE, increment o_txn_count.
REQ-022 Latency: acceptance edge N -> o_en_A high cycle N+1, o_en_B N+2, o_en_OP N+3, o_res_valid high from cycle N+5.
REQ-023 At most one strobe high in any cycle; all strobes 0 in IDLE, SETTLE, RESP.
REQ-024 o_ready=0 in every state except IDLE; i_valid and input changes outside IDLE ignored.
REQ-025 o_data=0 in IDLE, SETTLE, RESP.
REQ-026 i_res_ready held 0: remain in RESP indefinitely, outputs unchanged.
REQ-027 i_res_ready=1 in first RESP cycle: response consumed that edge; o_ready=1 next cycle; no back-to-back acceptance in the RESP cycle itself.
REQ-028 o_txn_count saturates at 16'hFFFF (no wrap).
REQ-029 o_result/o_zero/o_overflow retain last captured value after returning to IDLE until next capture.
REQ-030 Arithmetic: none performed; values passed bit-exact, no sign extension.

Reset
REQ-031 i_rst=0 at rising edge forces IDLE from any state, including mid-LOAD or RESP.
REQ-032 Reset values: o_ready=1 (cycle after reset), o_en_A/B/OP=0, o_data=0, o_res_valid=0, o_result=0, o_zero=0, o_overflow=0, o_txn_count=0, latched operands 0.
REQ-033 Reset overrides i_valid and i_res_ready in the same cycle.

Verification
REQ-034 A=123, B=45, op=6'b100000 with i_res_ready=1 -> strobes A,B,OP on consecutive cycles, o_res_valid at N+5, o_result=168, o_zero=0, o_txn_count=1.
REQ-035 A=50, B=100, op=6'b100010 -> o_result=8'd206 (0xCE), o_data during LOAD_OP = 8'b00100010.
REQ-036 A=0, B=0, op=6'b100000 -> o_result=0, o_zero=1; A=255, B=15, op=6'b100100 -> o_result=15.
REQ-037 Response backpressure: i_res_ready=0 for 20 cycles -> o_res_valid=1, o_result constant, o_ready=0, i_valid pulses ignored; then i_res_ready=1 -> IDLE next cycle, count +1.
REQ-038 Reset asserted during LOAD_B -> next cycle all strobes 0, o_res_valid=0, o_ready=1, o_txn_count=0; subsequent command completes normally.
REQ-039 Preload o_txn_count near saturation via 65535+ transactions (or forced) -> stays 16'hFFFF on further completions.
